// File: rtl/cpu_fetch_if.sv
// Bus bundle for cpu_fetch: program-RAM read port, redirect input,
// byte stream to the execute stage and perf counters.
interface cpu_fetch_if #(
  parameter int MEM_AW = 14,
  parameter int QDEPTH = 8
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic              i_redirect;
  logic [31:0]       i_redirect_pc;
  logic              o_mem_req;
  logic [MEM_AW-1:0] o_mem_addr;
  logic              i_mem_ack;
  logic [31:0]       i_mem_data;
  logic              o_byte_valid;
  logic [7:0]        o_byte;
  logic [31:0]       o_byte_pc;
  logic              i_byte_take;
  logic [CW-1:0]     o_count;
  logic [31:0]       o_perf_bytes;
  logic [31:0]       o_perf_stalls;

  modport master (
    input  i_redirect, i_redirect_pc, i_mem_ack, i_mem_data, i_byte_take,
    output o_mem_req, o_mem_addr, o_byte_valid, o_byte, o_byte_pc, o_count,
           o_perf_bytes, o_perf_stalls
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_mem_ack, i_mem_data, i_byte_take,
    input  o_mem_req, o_mem_addr, o_byte_valid, o_byte, o_byte_pc, o_count,
           o_perf_bytes, o_perf_stalls
  );
endinterface

// File: rtl/cpu_fetch.sv
// Instruction prefetch: word reads from program RAM into a byte queue.
// Define FETCH_PERF_EN to build the delivered-byte / stall perf counters.
module cpu_fetch #(
  parameter int          MEM_AW   = 14,
  parameter int          QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000FFFC
) (
  input logic         i_clk,
  input logic         i_rst,
  cpu_fetch_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   head_pc;
  logic [7:0]    queue [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          mem_req;

  logic [1:0]    k;
  logic          push_en;
  logic          pop_en;
  logic [2:0]    n_push;
  logic [CW-1:0] count_nxt;
  logic          req_nxt;

  // Request is registered from the post-update occupancy, so it reflects
  // the free space the queue will actually have in the request cycle.
  always_comb begin
    k         = fetch_pc[1:0];
    push_en   = mem_req && bus.i_mem_ack && !bus.i_redirect;
    pop_en    = bus.i_byte_take && (count != '0) && !bus.i_redirect;
    n_push    = push_en ? (3'd4 - {1'b0, k}) : 3'd0;
    count_nxt = bus.i_redirect ? '0 : (count + CW'(n_push) - CW'(pop_en));
    req_nxt   = !bus.i_redirect && (count_nxt <= CW'(QDEPTH - 4));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      mem_req  <= 1'b0;
      for (int unsigned i = 0; i < QDEPTH; i++) queue[i] <= '0;
    end else begin
      count   <= count_nxt;
      mem_req <= req_nxt;
      if (bus.i_redirect) begin
        fetch_pc <= bus.i_redirect_pc;
        head_pc  <= bus.i_redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (pop_en) begin
          rd_ptr  <= rd_ptr + PW'(1);
          head_pc <= head_pc + 32'd1;
        end
        if (push_en) begin
          fetch_pc <= {fetch_pc[31:2] + 30'd1, 2'b00};
          wr_ptr   <= wr_ptr + PW'(n_push);
        end
        // Bytes k..3 of the word land in consecutive queue slots.
        for (int unsigned j = 0; j < 4; j++) begin
          if (push_en && (j >= 32'(k)))
            queue[wr_ptr + PW'(j - 32'(k))] <= bus.i_mem_data[8*j +: 8];
        end
      end
    end
  end

  assign bus.o_mem_req    = mem_req;
  assign bus.o_mem_addr   = fetch_pc[MEM_AW+1:2];
  assign bus.o_byte_valid = (count != '0);
  assign bus.o_byte       = queue[rd_ptr];
  assign bus.o_byte_pc    = head_pc;
  assign bus.o_count      = count;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_bytes;
  logic [31:0] perf_stalls;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_bytes  <= '0;
      perf_stalls <= '0;
    end else begin
      if (pop_en)        perf_bytes  <= perf_bytes + 32'd1;
      if (count == '0)   perf_stalls <= perf_stalls + 32'd1;
    end
  end

  assign bus.o_perf_bytes  = perf_bytes;
  assign bus.o_perf_stalls = perf_stalls;
`else
  assign bus.o_perf_bytes  = '0;
  assign bus.o_perf_stalls = '0;
`endif
endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction prefetch stage for the 6502/65832 core. It issues word reads to the 32-bit-wide program RAM and buffers the returned bytes in a small byte queue. The execution stage consumes opcode and operand bytes one per cycle, each tagged with its byte PC. Jumps, branches, interrupts and mode switches redirect the stage; a redirect flushes the queue and discards any stale memory data.

## Interface
Parameters:
- MEM_AW, 14, word-address width of program RAM (16384 × 32-bit words = 64 KiB).
- QDEPTH, 8, byte-queue depth; power of two, ≥ 8.
- RESET_PC, 32'h0000FFFC, byte PC loaded at reset.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_redirect  in  1  load new fetch PC and flush queue.
- i_redirect_pc  in  32  new byte PC.
- o_mem_req  out  1  word read request.
- o_mem_addr  out  MEM_AW  word address, equal to fetch_pc[MEM_AW+1:2].
- i_mem_ack  in  1  read accepted; i_mem_data is valid in the same cycle.
- i_mem_data  in  32  read word, little-endian (byte 0 = [7:0]).
- o_byte_valid  out  1  queue head valid.
- o_byte  out  8  queue head byte.
- o_byte_pc  out  32  byte PC of the head byte.
- i_byte_take  in  1  consumer pops the head this cycle.
- o_count  out  $clog2(QDEPTH)+1  bytes held in the queue.
- o_perf_bytes  out  32  bytes delivered (perf counter).
- o_perf_stalls  out  32  empty-queue cycles (perf counter).

## Operation
- State: fetch_pc (32-bit byte pointer for the next word read), head_pc (32-bit), the byte queue with read/write pointers, and count.
- A transfer happens in a cycle where o_mem_req && i_mem_ack. Only one request is ever outstanding.
- o_mem_req is registered. It is high when (QDEPTH − count) ≥ 4 and no redirect occurred in the previous cycle. o_mem_addr is held stable while o_mem_req is high.
- On a transfer, with k = fetch_pc[1:0]:
  - bytes k..3 of i_mem_data are pushed in ascending order (4−k bytes);
  - fetch_pc becomes {fetch_pc[31:2]+1, 2'b00}.
- Pop: i_byte_take && o_byte_valid removes the head and increments head_pc by 1, wrapping mod 2^32. A take while the queue is empty is ignored.
- A push and a pop in the same cycle are both performed; count changes by pushed − popped.
- Redirect has highest priority:
  - fetch_pc and head_pc take i_redirect_pc;
  - the queue is emptied and count goes to 0;
  - a transfer in the same cycle is discarded;
  - a take in the same cycle is ignored;
  - o_mem_req goes low for exactly one cycle.
- Memory wrap: o_mem_addr wraps naturally mod 2^MEM_AW. fetch_pc itself is not truncated.
- Reset values:
  - o_mem_req 0, o_byte_valid 0, o_byte 0, o_count 0;
  - o_byte_pc RESET_PC, fetch_pc RESET_PC;
  - perf counters 0.
  - Reset mid-transfer abandons the transfer; the memory side must tolerate req dropping.

## Timing
- The cycle after reset deasserts: o_mem_req is 1 with o_mem_addr = RESET_PC[MEM_AW+1:2].
- Transfer in cycle T → first pushed byte is visible on o_byte_valid/o_byte at T+1.
- Redirect in cycle N → o_mem_req is 0 at N+1 and 1 at N+2. With an immediate ack, the first byte is valid at N+3.
- Sustained throughput with an always-acking memory: at least 1 byte/cycle (4 bytes per transfer, up to one transfer per cycle while space ≥ 4).
- o_byte, o_byte_pc and o_count are registered; there is no combinational path from i_byte_take to the outputs.

## Configuration
- FETCH_PERF_EN defined:
  - o_perf_bytes increments on every accepted pop;
  - o_perf_stalls increments on every cycle with o_byte_valid = 0, including the cycle after a redirect;
  - both counters wrap at 2^32; a redirect does not clear them.
- FETCH_PERF_EN undefined: both outputs are constant 0 and no counter flops exist.

## Test plan
- Reset, RAM word 0x3FFF = 32'hEAA9_00EA, ack always 1 → first bytes: 8'hEA at o_byte_pc 0x0000FFFC, then 8'h00 at 0x0000FFFD; o_mem_addr 0x3FFF, then 0x0000 (wrap).
- Redirect to 0x00000203, word 0x80 = 32'h4C00_0000 → exactly one byte (8'h4C at pc 0x203) comes from that word; the next request is at word 0x81.
- i_byte_take held 0, ack always 1 → o_count settles at 8 (QDEPTH), o_mem_req stays 0 while free space < 4, and no byte is lost or duplicated when takes resume.
- Ack delayed 5 cycles → o_mem_addr stable and o_mem_req held high throughout; redirect in the ack cycle → ack data absent from the queue and o_count = 0 the next cycle.
- Take and transfer in the same cycle with count = 3, fetch_pc[1:0] = 0 → o_count = 6 the next cycle; byte order is preserved.
- FETCH_PERF_EN defined, 20 takes plus 2 redirects → o_perf_bytes = 20, o_perf_stalls = the bench-counted empty cycles; without the macro both read 0.
